// File: rtl/div_unit.sv
// Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// Restoring division, one quotient bit per cycle, sign fix on the last edge.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       DivOp,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] DivResult
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             is_signed;
    logic             is_rem;
    logic             sign_a;
    logic             sign_b;
    logic             div_zero;
    logic             ovf;
    logic [WIDTH-1:0] min_neg;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   trial;
    logic [WIDTH+1:0] diff;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign is_signed = ~DivOp[0];
    assign is_rem    = DivOp[1];
    assign sign_a    = is_signed & SrcA[WIDTH-1];
    assign sign_b    = is_signed & SrcB[WIDTH-1];
    assign min_neg   = {1'b1, {(WIDTH-1){1'b0}}};
    assign mag_a     = sign_a ? -SrcA : SrcA;
    assign mag_b     = sign_b ? -SrcB : SrcB;
    assign div_zero  = (SrcB == '0);
    assign ovf       = is_signed & (SrcA == min_neg) & (SrcB == '1);

    // Shifted partial remainder can need WIDTH+1 bits when the divisor is large.
    assign trial   = {rem_q, quo_q[WIDTH-1]};
    assign diff    = {1'b0, trial} - {2'b00, dvs_q};
    assign quo_fix = negq_q ? -quo_q : quo_q;
    assign rem_fix = negr_q ? -rem_q : rem_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d   = DivOp;
                    negq_d = sign_a ^ sign_b;
                    negr_d = sign_a;
                    rem_d  = '0;
                    quo_d  = mag_a;
                    dvs_d  = mag_b;
                    cnt_d  = '0;
                    if (div_zero) begin
                        res_d  = is_rem ? SrcA : '1;
                        done_d = 1'b1;
                    end else if (ovf) begin
                        res_d  = is_rem ? '0 : min_neg;
                        done_d = 1'b1;
                    end else begin
                        state_d = S_CALC;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_CALC: begin
                if (diff[WIDTH+1]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end else begin
                    rem_d = diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                res_d   = op_q[1] ? rem_fix : quo_fix;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign DivResult = res_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus handshake and reset sequences.
// Latency is counted in rising edges after the start edge until done is seen.
module tb_div_unit;

    localparam int W = 32;
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   DivOp;
    logic [W-1:0] SrcA;
    logic [W-1:0] SrcB;
    logic         busy;
    logic         done;
    logic [W-1:0] DivResult;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .DivOp    (DivOp),
        .SrcA     (SrcA),
        .SrcB     (SrcB),
        .busy     (busy),
        .done     (done),
        .DivResult(DivResult)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        bit           fast;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            n_cmp++;
            if (done && busy) begin
                n_bad++;
                $display("FAIL done_with_busy: got done=1 busy=1 expected not both");
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the start edge.
    task automatic launch(input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        start = 1'b1;
        DivOp = op;
        SrcA  = a;
        SrcB  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        DivOp = 2'($urandom);
        SrcA  = $urandom;
        SrcB  = $urandom;
    endtask

    task automatic wait_done(input int inject_at, output int lat,
                             output int busy_hi);
        lat     = 0;
        busy_hi = 0;
        while (!done && lat < 100) begin
            if (busy) busy_hi++;
            if (lat == inject_at) begin
                start = 1'b1;
                DivOp = OP_DIV;
                SrcA  = 32'hFFFF_FFF8;
                SrcB  = 32'hFFFF_FFFE;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
    endtask

    initial begin
        int lat;
        int bh;
        int seen;

        vecs.push_back('{OP_DIVU, 32'd100,        32'd7,        32'd14,       1'b0});
        vecs.push_back('{OP_REMU, 32'd100,        32'd7,        32'd2,        1'b0});
        vecs.push_back('{OP_DIV,  32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 1'b0});
        vecs.push_back('{OP_REM,  32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{OP_REM,  32'd7,          32'hFFFF_FFFE, 32'd1,       1'b0});
        vecs.push_back('{OP_DIV,  32'hFFFF_FFF8,  32'hFFFF_FFFE, 32'd4,       1'b0});
        vecs.push_back('{OP_DIV,  32'd5,          32'd0,        32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{OP_DIVU, 32'd9,          32'd0,        32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{OP_REMU, 32'h1234,       32'd0,        32'h1234,     1'b1});
        vecs.push_back('{OP_REM,  32'hFFFF_FFF9,  32'd0,        32'hFFFF_FFF9, 1'b1});
        vecs.push_back('{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1});
        vecs.push_back('{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF, 32'd0,       1'b1});
        vecs.push_back('{OP_DIVU, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{OP_DIVU, 32'd3,          32'hFFFF_FFFF, 32'd0,       1'b0});
        vecs.push_back('{OP_REMU, 32'd3,          32'hFFFF_FFFF, 32'd3,       1'b0});
        vecs.push_back('{OP_DIV,  32'd0,          32'hFFFF_FFFB, 32'd0,       1'b0});
        vecs.push_back('{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,       1'b0});
        vecs.push_back('{OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0});
        vecs.push_back('{OP_DIV,  32'd1000,       32'hFFFF_FFF9, 32'hFFFF_FF72, 1'b0});
        vecs.push_back('{OP_REM,  32'hFFFF_FC18,  32'd7,        32'hFFFF_FFFA, 1'b0});

        rst   = 1'b1;
        start = 1'b0;
        DivOp = '0;
        SrcA  = '0;
        SrcB  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", W'(busy), 0);
        chk("reset_done", W'(done), 0);
        chk("reset_result", DivResult, 0);

        start = 1'b1;
        DivOp = OP_DIVU;
        SrcA  = 32'd100;
        SrcB  = 32'd7;
        @(posedge clk);
        #1;
        chk("rst_over_start_busy", W'(busy), 0);
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_over_start_idle", W'(busy), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(-1, lat, bh);
            chk($sformatf("vec%0d_result", i), DivResult, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), W'(lat), vecs[i].fast ? 0 : 33);
            chk($sformatf("vec%0d_busy_cycles", i), W'(bh), vecs[i].fast ? 0 : 33);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_done_pulse", i), W'(done), 0);
        end

        launch(OP_DIVU, 32'd100, 32'd7);
        wait_done(10, lat, bh);
        chk("ignored_start_result", DivResult, 32'd14);
        chk("ignored_start_latency", W'(lat), 33);
        @(posedge clk);
        #1;
        chk("ignored_start_no_second", W'(busy), 0);

        launch(OP_DIVU, 32'd100, 32'd7);
        wait_done(-1, lat, bh);
        chk("b2b_first_result", DivResult, 32'd14);
        launch(OP_REM, 32'hFFFF_FFF9, 32'd2);
        chk("b2b_done_dropped", W'(done), 0);
        chk("b2b_busy", W'(busy), 1);
        wait_done(-1, lat, bh);
        chk("b2b_second_result", DivResult, 32'hFFFF_FFFF);
        chk("b2b_second_latency", W'(lat), 33);

        launch(OP_DIVU, 32'd100, 32'd7);
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_busy", W'(busy), 0);
        chk("midrst_done", W'(done), 0);
        chk("midrst_result", DivResult, 0);
        rst  = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        chk("midrst_no_done", W'(seen), 0);
        launch(OP_DIVU, 32'd50, 32'd5);
        wait_done(-1, lat, bh);
        chk("after_rst_result", DivResult, 32'd10);
        chk("after_rst_latency", W'(lat), 33);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
Iterative multi-cycle RV32M divide/remainder unit. It implements DIV, DIVU, REM and REMU, which are the inverse counterparts of the single-cycle add/multiply-class ALU operations. It sits beside the ALU in the execute stage. The control path stalls the pipeline while busy is high and captures DivResult when done pulses.

Parameters:
- WIDTH, 32, operand and result width in bits. WIDTH must be a power of two and at least 8.

Ports:
- clk, input, 1, sole clock; all state updates on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- start, input, 1, request strobe; sampled only in IDLE.
- DivOp, input, 2, operation select: 00=DIV, 01=DIVU, 10=REM, 11=REMU.
- SrcA, input, WIDTH, dividend; sampled together with start.
- SrcB, input, WIDTH, divisor; sampled together with start.
- busy, output, 1, high while an operation is in flight (CALC or FIX).
- done, output, 1, one-cycle pulse when DivResult becomes valid.
- DivResult, output, WIDTH, quotient or remainder; held until the next accepted start or reset.

Behaviour:
- Reset, on any rising clk edge with rst=1, regardless of state:
  - state=IDLE, busy=0, done=0, DivResult=0, iteration counter=0.
  - Any operation in flight is discarded with no done pulse.
  - rst has priority over start.
- States:
  - IDLE: waiting for a request.
  - CALC: one restoring-division step per cycle.
  - FIX: sign correction and result load.
- IDLE transitions, on an edge with start=1:
  - Latch DivOp.
  - Latch the operand magnitudes: for DIV/REM, take the absolute value of each signed operand; for DIVU/REMU, take the raw operands.
  - Record negq = signA XOR signB and negr = signA (both signed ops only).
  - If the request is special (SrcB==0, or DIV/REM with SrcA=0x80000000 and SrcB=0xFFFFFFFF), take the fast path: load DivResult directly, done=1 next cycle, stay in IDLE, busy stays 0.
  - Otherwise go to CALC with busy=1 and counter=0.
- Fast-path values (WIDTH=32):
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give SrcA.
  - Signed overflow: DIV gives 0x80000000; REM gives 0.
- CALC: each edge shifts {rem, quo} left by one and trial-subtracts the divisor magnitude from rem. If there is no borrow, keep the difference and set the quotient LSB to 1. The counter increments. After exactly WIDTH CALC edges, go to FIX.
- FIX (single edge):
  - DivResult = quotient, negated if negq, for DIV/DIVU; remainder, negated if negr, for REM/REMU.
  - Negation applies only for signed ops.
  - done=1, busy=0, next state IDLE.
- Latency for a normal op (start sampled at edge T0):
  - busy high after T0.
  - CALC edges are T1..T32.
  - FIX occurs at T33.
  - done is high in the cycle following T33 only.
  - A new start is accepted at T34 or later; start is also accepted in the same cycle done is high, since the state is IDLE.
- Fast-path latency: done is high in the cycle after T0.
- start while busy=1 is ignored; there is no queueing and no error flag.
- SrcA, SrcB and DivOp changes after acceptance have no effect.
- done is never asserted together with busy.
- Rounding: the quotient truncates toward zero, and the remainder takes the sign of the dividend. This matches the RISC-V spec.
- Arithmetic uses WIDTH-bit magnitudes, with a WIDTH+1-bit trial subtraction to detect borrow.

Test Plan:
- Unsigned: DIVU, SrcA=100, SrcB=7 → done exactly 33 cycles after the start edge, DivResult=14; repeat with REMU → 2.
- Signed sign rules: DIV -7/2 → 0xFFFFFFFD (-3); REM -7/2 → 0xFFFFFFFF (-1); REM 7/-2 → 1; DIV -8/-2 → 4.
- Divide by zero and overflow: DIV x/0 → 0xFFFFFFFF; REMU 0x1234/0 → 0x1234; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0. For all four, done arrives 1 cycle after start with busy never high.
- Handshake: assert start again at cycle 10 of a busy op with different operands → ignored, first result unchanged. A back-to-back start on the cycle done is high is accepted, and the second result is correct.
- Reset mid-operation: rst=1 at cycle 15 of CALC → the next edge gives busy=0, done=0, DivResult=0. No done pulse follows, and a fresh DIVU 50/5 then yields 10.
- Boundary: DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF; DIVU 3/0xFFFFFFFF → 0; REMU 3/0xFFFFFFFF → 3; DIV 0/-5 → 0.
